// File: rtl/mode_cmd_filter.sv
// Mode-command frame parser/validator: checks 4-byte frames and forwards the mode byte
// only after CONFIRM_N identical valid frames; also reset-request, frame-error and link-loss reporting.
module mode_cmd_filter #(
    parameter logic [7:0] HDR_BYTE  = 8'hEB,
    parameter logic [7:0] RST_KEY   = 8'hA5,
    parameter int         CONFIRM_N = 3,
    parameter int         LINK_TO   = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx_sof,
    input  logic       i_rx_vld,
    input  logic [7:0] im_rx_data,
    input  logic       i_rx_eof,
    output logic [7:0] om_mode_byte,
    output logic       o_rst_req,
    output logic       o_frm_err,
    output logic       o_link_lost
);

    typedef enum logic [1:0] {S_IDLE, S_B1, S_B2, S_B3} state_t;

    localparam logic [3:0]  CONFIRM_MAX = 4'(CONFIRM_N);
    localparam logic [23:0] LINK_MAX    = 24'(LINK_TO);

    state_t      state_reg, state_next;
    logic [7:0]  b0_reg, b0_next;
    logic [7:0]  b1_reg, b1_next;
    logic [7:0]  b2_reg, b2_next;
    logic [7:0]  cand_reg, cand_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [23:0] timer_reg, timer_next;
    logic        prev_rst_reg, prev_rst_next;
    logic [7:0]  mode_reg, mode_next;
    logic        rst_req_reg, rst_req_next;
    logic        frm_err_reg, frm_err_next;
    logic        link_lost_reg, link_lost_next;

    logic        frame_ok;
    logic        frame_bad;
    logic        body_ok;

    // Fields of the frame being closed, checked against the B3 beat itself
    assign body_ok = (b0_reg == HDR_BYTE)
                  && (im_rx_data == (b0_reg ^ b1_reg ^ b2_reg))
                  && (b1_reg <= 8'h02);

    always_comb begin
        state_next = state_reg;
        b0_next    = b0_reg;
        b1_next    = b1_reg;
        b2_next    = b2_reg;
        frame_ok   = 1'b0;
        frame_bad  = 1'b0;
        if (i_rx_vld) begin
            if (state_reg == S_IDLE) begin
                if (i_rx_sof) begin
                    if (i_rx_eof) begin
                        frame_bad = 1'b1;
                    end else begin
                        b0_next    = im_rx_data;
                        state_next = S_B1;
                    end
                end
            end else if (i_rx_sof) begin
                // A new frame aborts the current one; the sof beat becomes the new B0
                frame_bad = 1'b1;
                if (i_rx_eof) begin
                    state_next = S_IDLE;
                end else begin
                    b0_next    = im_rx_data;
                    state_next = S_B1;
                end
            end else begin
                case (state_reg)
                    S_B1: begin
                        if (i_rx_eof) begin
                            frame_bad  = 1'b1;
                            state_next = S_IDLE;
                        end else begin
                            b1_next    = im_rx_data;
                            state_next = S_B2;
                        end
                    end
                    S_B2: begin
                        if (i_rx_eof) begin
                            frame_bad  = 1'b1;
                            state_next = S_IDLE;
                        end else begin
                            b2_next    = im_rx_data;
                            state_next = S_B3;
                        end
                    end
                    default: begin
                        state_next = S_IDLE;
                        if (i_rx_eof && body_ok) begin
                            frame_ok = 1'b1;
                        end else begin
                            frame_bad = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        cand_next     = cand_reg;
        cnt_next      = cnt_reg;
        mode_next     = mode_reg;
        prev_rst_next = prev_rst_reg;
        rst_req_next  = 1'b0;
        frm_err_next  = frame_bad;
        timer_next    = timer_reg;

        if (frame_ok) begin
            timer_next = 24'd0;
        end else if (timer_reg < LINK_MAX) begin
            timer_next = timer_reg + 24'd1;
        end

        if (frame_ok) begin
            if (b1_reg == cand_reg) begin
                cnt_next = (cnt_reg >= CONFIRM_MAX) ? CONFIRM_MAX : cnt_reg + 4'd1;
            end else begin
                cand_next = b1_reg;
                cnt_next  = 4'd1;
            end
            if (cnt_next == CONFIRM_MAX) begin
                mode_next = cand_next;
            end
            rst_req_next  = (b2_reg == RST_KEY) && !prev_rst_reg;
            prev_rst_next = (b2_reg == RST_KEY);
        end else if (frame_bad) begin
            cnt_next = 4'd0;
        end

        // Link loss forces a full re-confirmation once frames resume
        if (!frame_ok && timer_next == LINK_MAX) begin
            cnt_next = 4'd0;
        end
        link_lost_next = (timer_next == LINK_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            b0_reg        <= 8'h00;
            b1_reg        <= 8'h00;
            b2_reg        <= 8'h00;
            cand_reg      <= 8'hFF;
            cnt_reg       <= 4'd0;
            timer_reg     <= 24'd0;
            prev_rst_reg  <= 1'b0;
            mode_reg      <= 8'hFF;
            rst_req_reg   <= 1'b0;
            frm_err_reg   <= 1'b0;
            link_lost_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            b0_reg        <= b0_next;
            b1_reg        <= b1_next;
            b2_reg        <= b2_next;
            cand_reg      <= cand_next;
            cnt_reg       <= cnt_next;
            timer_reg     <= timer_next;
            prev_rst_reg  <= prev_rst_next;
            mode_reg      <= mode_next;
            rst_req_reg   <= rst_req_next;
            frm_err_reg   <= frm_err_next;
            link_lost_reg <= link_lost_next;
        end
    end

    assign om_mode_byte = mode_reg;
    assign o_rst_req    = rst_req_reg;
    assign o_frm_err    = frm_err_reg;
    assign o_link_lost  = link_lost_reg;

endmodule

// File: tb/tb_mode_cmd_filter.sv
// Directed scoreboard bench for mode_cmd_filter: the driver queues the expected
// {mode, rst_req, frm_err, link_lost} and flags a check cycle; the monitor pops and compares.
module tb_mode_cmd_filter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_rx_sof = 1'b0;
    logic       i_rx_vld = 1'b0;
    logic [7:0] im_rx_data = 8'h00;
    logic       i_rx_eof = 1'b0;
    logic [7:0] om_mode_byte;
    logic       o_rst_req;
    logic       o_frm_err;
    logic       o_link_lost;

    logic       chk_strobe = 1'b0;
    logic [10:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mode_cmd_filter #(
        .HDR_BYTE(8'hEB), .RST_KEY(8'hA5), .CONFIRM_N(3), .LINK_TO(50)
    ) dut (
        .clk(clk), .rst(rst),
        .i_rx_sof(i_rx_sof), .i_rx_vld(i_rx_vld), .im_rx_data(im_rx_data), .i_rx_eof(i_rx_eof),
        .om_mode_byte(om_mode_byte), .o_rst_req(o_rst_req),
        .o_frm_err(o_frm_err), .o_link_lost(o_link_lost)
    );

    // Monitor: compares on flagged cycles, and treats any unflagged pulse as a failure
    always @(negedge clk) begin
        logic [10:0] got;
        logic [10:0] want;
        got = {om_mode_byte, o_rst_req, o_frm_err, o_link_lost};
        if (!rst) begin
            if (chk_strobe) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL check#%0d: no expectation queued, got mode=%h rr=%b fe=%b ll=%b",
                             total, got[10:3], got[2], got[1], got[0]);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        bad++;
                        $display("FAIL check#%0d: got mode=%h rr=%b fe=%b ll=%b, want mode=%h rr=%b fe=%b ll=%b",
                                 total, got[10:3], got[2], got[1], got[0],
                                 want[10:3], want[2], want[1], want[0]);
                    end else begin
                        $display("check#%0d ok: mode=%h rr=%b fe=%b ll=%b",
                                 total, got[10:3], got[2], got[1], got[0]);
                    end
                end
            end else if (o_rst_req || o_frm_err) begin
                total++;
                bad++;
                $display("FAIL spurious_pulse at %0t: got rr=%b fe=%b, want rr=0 fe=0",
                         $time, o_rst_req, o_frm_err);
            end
        end
    end

    task automatic beat(input logic sof, input logic [7:0] data, input logic eof);
        i_rx_vld   = 1'b1;
        i_rx_sof   = sof;
        im_rx_data = data;
        i_rx_eof   = eof;
        @(posedge clk); #1;
        i_rx_vld = 1'b0;
        i_rx_sof = 1'b0;
        i_rx_eof = 1'b0;
    endtask

    task automatic frame(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] ck);
        beat(1'b1, 8'hEB, 1'b0);
        beat(1'b0, b1, 1'b0);
        beat(1'b0, b2, 1'b0);
        beat(1'b0, ck, 1'b1);
    endtask

    task automatic expect_now(input logic [7:0] mode, input logic rr, input logic fe, input logic ll);
        exp_q.push_back({mode, rr, fe, ll});
        chk_strobe = 1'b1;
        @(posedge clk); #1;
        chk_strobe = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        rst = 1'b0;
        expect_now(8'hFF, 0, 0, 0);

        // Confirmation of 02 after three identical frames (EB^02^00 = E9)
        frame(8'h02, 8'h00, 8'hE9); expect_now(8'hFF, 0, 0, 0);
        frame(8'h02, 8'h00, 8'hE9); expect_now(8'hFF, 0, 0, 0);
        frame(8'h02, 8'h00, 8'hE9); expect_now(8'h02, 0, 0, 0);

        // 00,00,01,00,00,00: switches to 00 only on the third 00 after the 01
        frame(8'h00, 8'h00, 8'hEB); expect_now(8'h02, 0, 0, 0);
        frame(8'h00, 8'h00, 8'hEB); expect_now(8'h02, 0, 0, 0);
        frame(8'h01, 8'h00, 8'hEA); expect_now(8'h02, 0, 0, 0);
        frame(8'h00, 8'h00, 8'hEB); expect_now(8'h02, 0, 0, 0);
        frame(8'h00, 8'h00, 8'hEB); expect_now(8'h02, 0, 0, 0);
        frame(8'h00, 8'h00, 8'hEB); expect_now(8'h00, 0, 0, 0);

        // Confirm 01, then a bad checksum between 00 frames clears the count
        frame(8'h01, 8'h00, 8'hEA); expect_now(8'h00, 0, 0, 0);
        frame(8'h01, 8'h00, 8'hEA); expect_now(8'h00, 0, 0, 0);
        frame(8'h01, 8'h00, 8'hEA); expect_now(8'h01, 0, 0, 0);
        frame(8'h00, 8'h00, 8'hEB); expect_now(8'h01, 0, 0, 0);
        frame(8'h00, 8'h00, 8'hEC); expect_now(8'h01, 0, 1, 0);
        frame(8'h00, 8'h00, 8'hEB); expect_now(8'h01, 0, 0, 0);
        frame(8'h00, 8'h00, 8'hEB); expect_now(8'h01, 0, 0, 0);
        frame(8'h00, 8'h00, 8'hEB); expect_now(8'h00, 0, 0, 0);

        // Reset request edge detection: A5, A5, 00, A5 (EB^00^A5 = 4E)
        frame(8'h00, 8'hA5, 8'h4E); expect_now(8'h00, 1, 0, 0);
        frame(8'h00, 8'hA5, 8'h4E); expect_now(8'h00, 0, 0, 0);
        frame(8'h00, 8'h00, 8'hEB); expect_now(8'h00, 0, 0, 0);
        frame(8'h00, 8'hA5, 8'h4E); expect_now(8'h00, 1, 0, 0);

        // sof on B2 aborts the frame; the restarted frame (01) counts as valid
        beat(1'b1, 8'hEB, 1'b0);
        beat(1'b0, 8'h01, 1'b0);
        beat(1'b1, 8'hEB, 1'b0);
        expect_now(8'h00, 0, 1, 0);
        beat(1'b0, 8'h01, 1'b0);
        beat(1'b0, 8'h00, 1'b0);
        beat(1'b0, 8'hEA, 1'b1);
        expect_now(8'h00, 0, 0, 0);
        frame(8'h01, 8'h00, 8'hEA); expect_now(8'h00, 0, 0, 0);
        frame(8'h01, 8'h00, 8'hEA); expect_now(8'h01, 0, 0, 0);

        // Early eof on B1, a stray beat without sof, and an out-of-range mode byte
        beat(1'b1, 8'hEB, 1'b0);
        beat(1'b0, 8'h01, 1'b1);
        expect_now(8'h01, 0, 1, 0);
        beat(1'b0, 8'h12, 1'b0);
        expect_now(8'h01, 0, 0, 0);
        frame(8'h03, 8'h00, 8'hE8); expect_now(8'h01, 0, 1, 0);

        // Link loss after 50 idle cycles clears the count for candidate 02
        frame(8'h02, 8'h00, 8'hE9); expect_now(8'h01, 0, 0, 0);
        frame(8'h02, 8'h00, 8'hE9);
        expect_now(8'h01, 0, 0, 0);
        idle(48);
        expect_now(8'h01, 0, 0, 0);
        expect_now(8'h01, 0, 0, 1);
        idle(5);
        expect_now(8'h01, 0, 0, 1);
        frame(8'h02, 8'h00, 8'hE9); expect_now(8'h01, 0, 0, 0);
        frame(8'h02, 8'h00, 8'hE9); expect_now(8'h01, 0, 0, 0);
        frame(8'h02, 8'h00, 8'hE9); expect_now(8'h02, 0, 0, 0);

        // Reset mid-frame discards the partial frame without an error
        beat(1'b1, 8'hEB, 1'b0);
        beat(1'b0, 8'h01, 1'b0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        expect_now(8'hFF, 0, 0, 0);
        beat(1'b0, 8'h00, 1'b0);
        beat(1'b0, 8'hEA, 1'b1);
        expect_now(8'hFF, 0, 0, 0);

        idle(2);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL leftover_expectations: got %0d queued, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
